// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one SDRAM controller command port; an in-order owner FIFO routes completions back.
// Optional SDRAM_ARB_STATS_EN adds per-port accept counters and a stall-cycle counter.
module sdram_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 24,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_rd,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]              req_rdy,
  output logic [NUM_PORTS-1:0]              req_rvalid,
  output logic [NUM_PORTS-1:0]              req_wvalid,
  output logic [DATA_WIDTH-1:0]             req_rdata,
  output logic                              mem_rd,
  output logic [DATA_WIDTH/8-1:0]           mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_rdy,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_rvalid,
  input  logic                              mem_wvalid,
`ifdef SDRAM_ARB_STATS_EN
  output logic [NUM_PORTS*32-1:0]           stat_accepts,
  output logic [31:0]                       stat_stall,
`endif
  output logic                              err
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PORT_W-1:0] r_rr_ptr;
  logic [PORT_W-1:0] r_own_port [MAX_OUTSTANDING];
  logic              r_own_wr   [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  logic              r_err;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_hi_vld, w_lo_vld, w_gnt_vld, w_gnt_wr, w_accept;
  logic [PORT_W-1:0]    w_hi, w_lo, w_gnt, w_head_port;
  logic [BE_W-1:0]      w_gnt_be;
  logic                 w_full, w_empty, w_cpl, w_pop, w_head_wr, w_cpl_err;

  assign w_full  = (r_count == (PTR_W+1)'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // Two descending scans leave the lowest requester at/after rr_ptr (hi) and the lowest overall (lo).
  always_comb begin
    w_req    = '0;
    w_hi_vld = 1'b0;
    w_hi     = '0;
    w_lo_vld = 1'b0;
    w_lo     = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      w_req[p] = req_rd[p] | (|req_wr[p*BE_W +: BE_W]);
      if (w_req[p]) begin
        w_lo_vld = 1'b1;
        w_lo     = PORT_W'(p);
        if (PORT_W'(p) >= r_rr_ptr) begin
          w_hi_vld = 1'b1;
          w_hi     = PORT_W'(p);
        end
      end
    end
  end

  assign w_gnt_vld = w_lo_vld & ~w_full & ~rst;
  assign w_gnt     = w_hi_vld ? w_hi : w_lo;
  assign w_gnt_be  = req_wr[w_gnt*BE_W +: BE_W];
  assign w_gnt_wr  = |w_gnt_be;
  assign w_accept  = w_gnt_vld & mem_rdy;

  assign mem_rd    = w_gnt_vld & ~w_gnt_wr;
  assign mem_wr    = w_gnt_vld ? w_gnt_be : '0;
  assign mem_addr  = w_gnt_vld ? req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata = w_gnt_vld ? req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign w_head_port = r_own_port[r_rptr];
  assign w_head_wr   = r_own_wr[r_rptr];
  assign w_cpl       = mem_rvalid | mem_wvalid;
  assign w_pop       = w_cpl & ~w_empty;
  assign w_cpl_err   = (w_cpl & w_empty) | (mem_rvalid & mem_wvalid) |
                       (w_pop & ((mem_rvalid & w_head_wr) | (mem_wvalid & ~w_head_wr)));
  assign req_rdata   = mem_rvalid ? mem_rdata : '0;
  assign err         = r_err;

  // A double completion is routed by what the head owner actually issued.
  always_comb begin
    req_rdy    = '0;
    req_rvalid = '0;
    req_wvalid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_rdy[p] = w_accept && (w_gnt == PORT_W'(p));
      if (w_pop && (w_head_port == PORT_W'(p))) begin
        if (mem_rvalid && mem_wvalid) begin
          req_rvalid[p] = ~w_head_wr;
          req_wvalid[p] = w_head_wr;
        end else begin
          req_rvalid[p] = mem_rvalid;
          req_wvalid[p] = mem_wvalid;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_own_port[r_wptr] <= w_gnt;
      r_own_wr[r_wptr]   <= w_gnt_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr   <= r_wptr + 1'b1;
        r_rr_ptr <= (w_gnt == PORT_W'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
      if (w_cpl_err) r_err <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] r_stat_acc [NUM_PORTS];
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) r_stat_acc[p] <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (w_accept && (w_gnt == PORT_W'(p))) r_stat_acc[p] <= r_stat_acc[p] + 1'b1;
      if (w_gnt_vld && !mem_rdy) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  always_comb begin
    stat_accepts = '0;
    for (int p = 0; p < NUM_PORTS; p++) stat_accepts[p*32 +: 32] = r_stat_acc[p];
  end
  assign stat_stall = r_stat_stall;
`endif
endmodule
